axi_aw_arbiter_mux_n: RTL
=========================

Name: axi_aw_arbiter_mux_n

Overview:
- N-master write-address arbiter and multiplexer with round-robin arbitration and a registered output slice toward a single slave port.
- Records the grant order of accepted AW transactions in a write-order FIFO, so the W-channel mux routes write data beats from the correct master.
- Sits in the interconnect datapath, one instance per slave port.
- Generalises the fixed 2:1 AW select to N masters with internal arbitration, AW handshake and W routing.

Parameters:
- NUM_MASTERS, 4, number of upstream masters, 2..16.
- ADDR_WIDTH, 32, awaddr width.
- LEN_WIDTH, 8, awlen width (AXI4).
- WFIFO_DEPTH, 4, write-order FIFO entries, power of two ≥ 2.
- Derived localparam IDW = max(1, clog2(NUM_MASTERS)).

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESET  in  1  asynchronous active-high reset.
- S_AXI_awaddr  in  NUM_MASTERS*ADDR_WIDTH  packed per-master addresses; master i at slice i.
- S_AXI_awlen  in  NUM_MASTERS*LEN_WIDTH  burst lengths.
- S_AXI_awsize  in  NUM_MASTERS*3  beat size.
- S_AXI_awburst  in  NUM_MASTERS*2  burst type.
- S_AXI_awlock  in  NUM_MASTERS*2  lock type.
- S_AXI_awcache  in  NUM_MASTERS*4  cache attributes.
- S_AXI_awprot  in  NUM_MASTERS*3  protection.
- S_AXI_awqos  in  NUM_MASTERS*4  QoS.
- S_AXI_awvalid  in  NUM_MASTERS  per-master valid.
- S_AXI_awready  out  NUM_MASTERS  per-master ready; one-hot or zero.
- M_AXI_awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos  out  same per-field widths  registered selected payload.
- M_AXI_awvalid  out  1  registered valid.
- M_AXI_awready  in  1  slave ready.
- W_sel_id  out  IDW  master index owning the current W burst (FIFO head).
- W_sel_valid  out  1  FIFO non-empty.
- W_sel_pop  in  1  pulse on the WLAST handshake of the current burst.

Behaviour:
- Reset (async assert, sync release):
  - M_AXI_awvalid=0, all M_AXI payload=0, S_AXI_awready=0.
  - RR pointer=0, FIFO empty, W_sel_valid=0, W_sel_id=0.
- Slice can_load = (!M_AXI_awvalid || M_AXI_awready) && !fifo_full.
  - Full blocks loading even if W_sel_pop is high in the same cycle; pop does not bypass.
- Arbitration (combinational):
  - Winner = first i with S_AXI_awvalid[i], scanning from the RR pointer upward with wrap at NUM_MASTERS-1 → 0.
  - S_AXI_awready[winner] = can_load; all other ready bits 0.
  - awready never depends on a master's own awvalid being held; the grant is recomputed every cycle.
- Accept = can_load && any valid. On the accept edge:
  - Winner payload loads into the M_AXI registers; M_AXI_awvalid=1.
  - Winner index pushed to the FIFO.
  - RR pointer ← (winner+1) mod NUM_MASTERS.
- Latency: master handshake in cycle t → M_AXI_awvalid high in cycle t+1.
  - Back-to-back throughput is 1/cycle while M_AXI_awready=1.
- Output hold: while M_AXI_awvalid && !M_AXI_awready, payload and valid stay stable (AXI rule).
  - If M_AXI_awready=1 and nothing is accepted, M_AXI_awvalid→0 next cycle; payload keeps its last value.
- No valid inputs: pointer unchanged, no push.
- Write-order FIFO:
  - Depth WFIFO_DEPTH; wrap-around read/write pointers plus an extra bit for full/empty.
  - W_sel_id = head entry, combinational from storage.
  - Pop on W_sel_pop && !empty; pop on empty is ignored.
  - Simultaneous push and pop when non-empty and non-full: count unchanged, both pointers advance.
  - Push while empty: W_sel_valid rises the next cycle.
- A master dropping awvalid before its handshake is tolerated (protocol violation upstream); no state corruption.
- Reset asserted mid-transfer: everything clears immediately, in-flight AW and FIFO contents are discarded.

Test Plan:
- Reset → M_AXI_awvalid=0, S_AXI_awready=0000, W_sel_valid=0; master1 valid addr 0x1000 with M_AXI_awready=1 → awready=0010, next cycle M_AXI_awaddr=0x1000, W_sel_id=1.
- All 4 masters continuously valid, M_AXI_awready=1 → grant order 0,1,2,3,0; FIFO entries 0,1,2,3 with W_sel_pop each cycle after the first.
- Master2 accepted, then M_AXI_awready=0 for 3 cycles → M_AXI_awaddr/awlen stable, S_AXI_awready=0 throughout; release → master3 accepted the same cycle.
- WFIFO_DEPTH=4, no pops, 4 accepts → fifo_full, all awready=0 even with M_AXI_awready=1; single W_sel_pop → one more accept the following cycle.
- W_sel_pop on empty FIFO → W_sel_valid stays 0, later push yields correct W_sel_id; simultaneous push+pop at count 2 → count stays 2.
- ARESET pulsed while M_AXI_awvalid=1 and FIFO holds 3 entries → immediate M_AXI_awvalid=0, W_sel_valid=0, first grant after release goes to master 0.

Source files
------------

// File: rtl/axi_aw_arbiter_mux_n.sv
// N-master AW round-robin arbiter with a registered output slice toward one slave port.
// A write-order FIFO records each accepted grant so the W mux can follow AW order.
module axi_aw_arbiter_mux_n #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH   = 8,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic                               ACLK,
   input  logic                               ARESET,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  S_AXI_awaddr,
   input  logic [NUM_MASTERS*LEN_WIDTH-1:0]   S_AXI_awlen,
   input  logic [NUM_MASTERS*3-1:0]           S_AXI_awsize,
   input  logic [NUM_MASTERS*2-1:0]           S_AXI_awburst,
   input  logic [NUM_MASTERS*2-1:0]           S_AXI_awlock,
   input  logic [NUM_MASTERS*4-1:0]           S_AXI_awcache,
   input  logic [NUM_MASTERS*3-1:0]           S_AXI_awprot,
   input  logic [NUM_MASTERS*4-1:0]           S_AXI_awqos,
   input  logic [NUM_MASTERS-1:0]             S_AXI_awvalid,
   output logic [NUM_MASTERS-1:0]             S_AXI_awready,
   output logic [ADDR_WIDTH-1:0]              M_AXI_awaddr,
   output logic [LEN_WIDTH-1:0]               M_AXI_awlen,
   output logic [2:0]                         M_AXI_awsize,
   output logic [1:0]                         M_AXI_awburst,
   output logic [1:0]                         M_AXI_awlock,
   output logic [3:0]                         M_AXI_awcache,
   output logic [2:0]                         M_AXI_awprot,
   output logic [3:0]                         M_AXI_awqos,
   output logic                               M_AXI_awvalid,
   input  logic                               M_AXI_awready,
   output logic [((NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1)-1:0] W_sel_id,
   output logic                               W_sel_valid,
   input  logic                               W_sel_pop
);

   localparam int IDW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
   localparam int FAW = $clog2(WFIFO_DEPTH);

   logic [IDW-1:0]        r_rr_ptr;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [LEN_WIDTH-1:0]  r_awlen;
   logic [2:0]            r_awsize;
   logic [1:0]            r_awburst;
   logic [1:0]            r_awlock;
   logic [3:0]            r_awcache;
   logic [2:0]            r_awprot;
   logic [3:0]            r_awqos;
   logic                  r_awvalid;

   logic [IDW-1:0]        r_fifo [WFIFO_DEPTH];
   logic [FAW:0]          r_wptr;
   logic [FAW:0]          r_rptr;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_can_load;
   logic                  w_any;
   logic                  w_accept;
   logic                  w_pop;
   int                    w_win_idx;
   logic [IDW-1:0]        w_winner;
   logic [IDW-1:0]        w_rr_next;

   logic [ADDR_WIDTH-1:0] w_sel_awaddr;
   logic [LEN_WIDTH-1:0]  w_sel_awlen;
   logic [2:0]            w_sel_awsize;
   logic [1:0]            w_sel_awburst;
   logic [1:0]            w_sel_awlock;
   logic [3:0]            w_sel_awcache;
   logic [2:0]            w_sel_awprot;
   logic [3:0]            w_sel_awqos;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[FAW] != r_rptr[FAW]) && (r_wptr[FAW-1:0] == r_rptr[FAW-1:0]);

   // A full order FIFO stalls AW even if a pop arrives this cycle; pop never bypasses.
   assign w_can_load = (!r_awvalid || M_AXI_awready) && !w_full && !ARESET;
   assign w_accept   = w_can_load && w_any;
   assign w_pop      = W_sel_pop && !w_empty;

   // Scan downward so the last hit is the first valid master at or after the pointer.
   always_comb begin
      int idx;
      w_any     = 1'b0;
      w_win_idx = 0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         idx = (int'(r_rr_ptr) + k) % NUM_MASTERS;
         if (S_AXI_awvalid[idx]) begin
            w_any     = 1'b1;
            w_win_idx = idx;
         end
      end
   end

   assign w_winner  = IDW'(w_win_idx);
   assign w_rr_next = IDW'((w_win_idx + 1) % NUM_MASTERS);

   always_comb begin
      S_AXI_awready = '0;
      if (w_accept) begin
         S_AXI_awready[w_win_idx] = 1'b1;
      end
   end

   always_comb begin
      w_sel_awaddr  = S_AXI_awaddr[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      w_sel_awlen   = S_AXI_awlen[w_win_idx*LEN_WIDTH +: LEN_WIDTH];
      w_sel_awsize  = S_AXI_awsize[w_win_idx*3 +: 3];
      w_sel_awburst = S_AXI_awburst[w_win_idx*2 +: 2];
      w_sel_awlock  = S_AXI_awlock[w_win_idx*2 +: 2];
      w_sel_awcache = S_AXI_awcache[w_win_idx*4 +: 4];
      w_sel_awprot  = S_AXI_awprot[w_win_idx*3 +: 3];
      w_sel_awqos   = S_AXI_awqos[w_win_idx*4 +: 4];
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rr_ptr  <= '0;
         r_awvalid <= 1'b0;
         r_awaddr  <= '0;
         r_awlen   <= '0;
         r_awsize  <= '0;
         r_awburst <= '0;
         r_awlock  <= '0;
         r_awcache <= '0;
         r_awprot  <= '0;
         r_awqos   <= '0;
      end else if (w_accept) begin
         r_rr_ptr  <= w_rr_next;
         r_awvalid <= 1'b1;
         r_awaddr  <= w_sel_awaddr;
         r_awlen   <= w_sel_awlen;
         r_awsize  <= w_sel_awsize;
         r_awburst <= w_sel_awburst;
         r_awlock  <= w_sel_awlock;
         r_awcache <= w_sel_awcache;
         r_awprot  <= w_sel_awprot;
         r_awqos   <= w_sel_awqos;
      end else if (M_AXI_awready) begin
         r_awvalid <= 1'b0;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < WFIFO_DEPTH; i++) begin
            r_fifo[i] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_fifo[r_wptr[FAW-1:0]] <= w_winner;
            r_wptr                  <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   assign M_AXI_awaddr  = r_awaddr;
   assign M_AXI_awlen   = r_awlen;
   assign M_AXI_awsize  = r_awsize;
   assign M_AXI_awburst = r_awburst;
   assign M_AXI_awlock  = r_awlock;
   assign M_AXI_awcache = r_awcache;
   assign M_AXI_awprot  = r_awprot;
   assign M_AXI_awqos   = r_awqos;
   assign M_AXI_awvalid = r_awvalid;

   assign W_sel_id    = r_fifo[r_rptr[FAW-1:0]];
   assign W_sel_valid = !w_empty;

endmodule
